// File: rtl/divider_seq.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock over a
// combined 64-bit remainder/quotient shift register, with a one-cycle done pulse.
module divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] rq;
    logic [31:0] dvs;
    logic [4:0]  cnt;
    logic        accept;
    logic [32:0] trial;

    // A new request is taken in IDLE or DONE, which is what allows back-to-back runs.
    assign accept = start && (state != RUN);

    // rq[63:31] is the upper 33 bits of {rq, 1'b0}: the shifted partial remainder,
    // keeping the bit that shifts out of position 63.
    assign trial = rq[63:31] - {1'b0, dvs};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (divisor == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == 5'd31) state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = (divisor == 32'd0) ? DONE : RUN;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: the datapath registers are reset too, so quotient/remainder read as
    // zero out of reset and after an aborted run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq          <= 64'd0;
            dvs         <= 32'd0;
            cnt         <= 5'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor != 32'd0) begin
                rq          <= {32'd0, dividend};
                dvs         <= divisor;
                cnt         <= 5'd0;
                div_by_zero <= 1'b0;
            end else begin
                rq          <= {dividend, 32'hFFFF_FFFF};
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            // Restore on a negative trial by keeping the shifted remainder.
            if (trial[32]) begin
                rq <= {rq[62:31], rq[30:0], 1'b0};
            end else begin
                rq <= {trial[31:0], rq[30:0], 1'b1};
            end
            cnt <= cnt + 5'd1;
        end
    end

    assign quotient  = rq[31:0];
    assign remainder = rq[63:32];

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential 32-bit unsigned shift-subtract (restoring) divider: the inverse counterpart of the multiplier2 shift-add datapath. It takes a dividend and divisor on a start pulse and runs one quotient bit per clock over a combined 64-bit remainder/quotient shift register. It returns quotient and remainder with a one-cycle done pulse. Control FSM, iteration counter and datapath live in this one block.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a division. Accepted only when busy=0.
- dividend  input  32  unsigned dividend, sampled on the accept edge.
- divisor  input  32  unsigned divisor, sampled on the accept edge.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on.
- quotient  output  32  result quotient, held until the next accept.
- remainder  output  32  result remainder, held until the next accept.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

## Operation
- Internal state:
  - rq[63:0]: upper half is the partial remainder, lower half is the dividend/quotient.
  - dvs[31:0]: latched divisor.
  - cnt[4:0]: iteration counter.
- FSM states are IDLE, RUN and DONE.
- IDLE or DONE with start=1 (accept):
  - divisor!=0: rq<={32'b0, dividend}, dvs<=divisor, cnt<=0, div_by_zero<=0, go to RUN.
  - divisor==0: rq<={dividend, 32'hFFFF_FFFF}, div_by_zero<=1, go to DONE. No iterations run.
- RUN, per cycle:
  - Shift: s = {rq[63:0], 1'b0}, 65 bits.
  - Trial subtract in 33 bits: t = s[64:32] - {1'b0, dvs}.
  - t non-negative (t[32]==0): rq <= {t[31:0], s[31:1], 1'b1}.
  - Otherwise: rq <= {s[63:32], s[31:1], 1'b0}.
  - cnt <= cnt+1. If cnt==31, go to DONE.
- DONE: done=1 for exactly this cycle.
  - Without start: next state is IDLE.
  - With start: the accept rules above apply, so back-to-back operations are allowed.
- quotient = rq[31:0] and remainder = rq[63:32]. Both are driven from registers, so they are valid in DONE and stable in IDLE.
- start while busy=1 is ignored. It is neither queued nor does it disturb the operation in progress.
- Operands may change freely after the accept edge.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. State is IDLE, cnt=0.
- Reset mid-RUN aborts immediately. No done is produced.
- Normal latency:
  - Accept edge is E0. Iterations occur at E1..E32.
  - busy is high from after E0 through E32.
  - done is high for the cycle following E32.
  - Start to done is therefore 33 clock edges.
- Divide-by-zero latency: done is high in the cycle right after the accept edge (1 edge). busy stays 0.
- Throughput: one division per 33 cycles when start is held high or re-pulsed in DONE.
- done and busy are never high in the same cycle.
- The 33-bit trial subtract covers partial remainders with bit 31 set after the shift, e.g. a divisor ≥ 0x8000_0001. No overflow is lost.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- 100 / 7 → after 33 edges: done=1, quotient=14, remainder=2, div_by_zero=0. busy high for exactly 32 cycles.
- 0xFFFF_FFFF / 1 → quotient=0xFFFF_FFFF, remainder=0. Also 0x8000_0000 / 0xFFFF_FFFF → quotient=0, remainder=0x8000_0000. Also 0xFFFF_FFFE / 0xFFFF_FFFF → quotient=0, remainder=0xFFFF_FFFE.
- 5 / 0 → done one edge after accept, div_by_zero=1, quotient=0xFFFF_FFFF, remainder=5, busy never high.
- Start pulsed with 9/4 at cycle 10 of a 1000/3 run → ignored. Result is quotient=333, remainder=1, and no extra done.
- rst asserted mid-RUN (cnt=15) → all outputs 0 asynchronously, then IDLE. A subsequent 50/5 gives quotient=10, remainder=0.
- Back-to-back: start held high, 81/9 then 17/5 → two done pulses 33 cycles apart with (9,0) then (3,2). Random operands are checked against a reference model of / and %.
